// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
//
// Queues read/write commands in a small FIFO and issues each one as a single
// classic Wishbone cycle. For every completed cycle it produces a one-cycle
// response pulse.
//
// Each transaction goes through IDLE -> BUS -> RESP. As a result, two bus
// cycles are always separated by at least one cycle with wb_stb_o low.
//
// Parameters
//   AW      Wishbone address width
//   DW      data width
//   DEPTH   command FIFO entries (power of 2, >= 2)
//   TIMEOUT ack-wait limit in BUS cycles (>= 2), used only with the macro below
//
// Optional feature
//   `define WB_CMD_MASTER_TIMEOUT_EN enables the ack timeout. While a cycle
//   waits for ack, the timeout counts BUS cycles. After TIMEOUT cycles without
//   an ack, it ends the cycle with rsp_err_o = 1. Without the macro, the block
//   waits for ack forever and rsp_err_o is tied to 0.
//
// Ports
//   wb_clk_i, arst_i           clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o  command handshake (cmd_we_i, cmd_addr_i, cmd_data_i)
//   rsp_valid_o                one-cycle response pulse
//   rsp_data_o                 read data (0 for writes and errors)
//   rsp_err_o                  timeout flag, qualified by rsp_valid_o
//   busy_o, level_o            activity flag, FIFO occupancy
//   wb_*                       Wishbone master signals; cyc and stb are driven together
//   wb_inta_i / irq_o          slave interrupt, registered once
// -----------------------------------------------------------------------------
module wb_cmd_master #(
  parameter int AW      = 3,
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       arst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_we_i,
  input  logic [AW-1:0]              cmd_addr_i,
  input  logic [DW-1:0]              cmd_data_i,
  output logic                       rsp_valid_o,
  output logic [DW-1:0]              rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [AW-1:0]              wb_addr_o,
  output logic [DW-1:0]              wb_dat_o,
  input  logic [DW-1:0]              wb_dat_i,
  output logic                       wb_we_o,
  output logic                       wb_stb_o,
  output logic                       wb_cyc_o,
  input  logic                       wb_ack_i,
  input  logic                       wb_inta_i,
  output logic                       irq_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  // Reject bad parameter values at elaboration time.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_cmd_master: DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic [DW-1:0]   wb_dat_q, wb_dat_d;
  logic            wb_we_q, wb_we_d;
  logic            wb_stb_q, wb_stb_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            irq_q;
  logic            push, pop;

  // FIFO storage
  logic            mem_we_q   [DEPTH];
  logic [AW-1:0]   mem_addr_q [DEPTH];
  logic [DW-1:0]   mem_data_q [DEPTH];

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT);
  logic [TCW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  assign cmd_ready_o = (level_q != LW'(DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;

  // NOTE: payload storage has no reset. The level/pointer logic never reads an
  // empty slot, and leaving it unreset keeps it as plain RAM.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_we_q[wr_ptr_q]   <= cmd_we_i;
      mem_addr_q[wr_ptr_q] <= cmd_addr_i;
      mem_data_q[wr_ptr_q] <= cmd_data_i;
    end
  end

  // Next-state logic and outputs.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wb_addr_d   = wb_addr_q;
    wb_dat_d    = wb_dat_q;
    wb_we_d     = wb_we_q;
    wb_stb_d    = wb_stb_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          pop       = 1'b1;
          wb_addr_d = mem_addr_q[rd_ptr_q];
          wb_dat_d  = mem_data_q[rd_ptr_q];
          wb_we_d   = mem_we_q[rd_ptr_q];
          wb_stb_d  = 1'b1;
          state_d   = ST_BUS;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end

      ST_BUS: begin
        if (wb_ack_i) begin
          // An ack always wins, even on the edge where the timeout expires.
          wb_stb_d    = 1'b0;
          wb_we_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = wb_we_q ? '0 : wb_dat_i;
          state_d     = ST_RESP;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_cnt_q == TCW'(TIMEOUT - 1)) begin
          // This edge ends the TIMEOUT-th BUS cycle with no ack seen.
          wb_stb_d    = 1'b0;
          wb_we_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + 1'b1;
`endif
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Power-of-2 DEPTH means the pointers wrap naturally.
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge, regardless of process order.
  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wb_addr_q   <= '0;
      wb_dat_q    <= '0;
      wb_we_q     <= 1'b0;
      wb_stb_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wb_addr_q   <= wb_addr_d;
      wb_dat_q    <= wb_dat_d;
      wb_we_q     <= wb_we_d;
      wb_stb_q    <= wb_stb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      irq_q       <= wb_inta_i;
    end
  end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (level_q != '0) || (state_q != ST_IDLE);
  assign level_o     = level_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_dat_o    = wb_dat_q;
  assign wb_we_o     = wb_we_q;
  assign wb_stb_o    = wb_stb_q;
  assign wb_cyc_o    = wb_stb_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_wb_cmd_master
//
// Directed testbench for wb_cmd_master with its default parameters
// (AW=3, DW=8, DEPTH=4, TIMEOUT=16).
//
// Inputs are driven and outputs are sampled on the falling clock edge. The
// design updates on the rising edge, so sampling never races it. The timeout
// scenarios are compiled in only when WB_CMD_MASTER_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_wb_cmd_master;

  logic       clk = 1'b0;
  logic       arst_i;
  logic       cmd_valid_i, cmd_we_i;
  logic [2:0] cmd_addr_i;
  logic [7:0] cmd_data_i;
  logic       cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o;
  logic [7:0] rsp_data_o;
  logic [2:0] level_o;
  logic [2:0] wb_addr_o;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_inta_i, irq_o;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  wb_cmd_master dut (
    .wb_clk_i   (clk),
    .arst_i     (arst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_data_i (cmd_data_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o),
    .busy_o     (busy_o),
    .level_o    (level_o),
    .wb_addr_o  (wb_addr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i),
    .wb_inta_i  (wb_inta_i),
    .irq_o      (irq_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offers one command through the next rising edge. cmd_valid_i stays high,
  // so consecutive calls push back-to-back.
  task automatic push(input logic we, input logic [2:0] addr, input logic [7:0] data);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_data_i  = data;
    check("push_ready", cmd_ready_o, 1);
    @(negedge clk);
  endtask

  // Waits, with a bound, for wb_stb_o. Returns the number of low samples seen.
  task automatic wait_stb(input string tag, input int max_cyc, output int low_cycles);
    low_cycles = 0;
    while (wb_stb_o !== 1'b1 && low_cycles < max_cyc) begin
      @(negedge clk);
      low_cycles++;
    end
    check(tag, wb_stb_o, 1);
  endtask

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, hi, pulses;

    arst_i      = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_addr_i  = '0;
    cmd_data_i  = '0;
    wb_dat_i    = '0;
    wb_ack_i    = 1'b0;
    wb_inta_i   = 1'b0;

    // ---- reset state ----
    #1;
    check("rst_ready", cmd_ready_o, 1);
    check("rst_stb",   wb_stb_o,    0);
    check("rst_cyc",   wb_cyc_o,    0);
    check("rst_level", level_o,     0);
    check("rst_busy",  busy_o,      0);
    check("rst_rspv",  rsp_valid_o, 0);
    check("rst_addr",  wb_addr_o,   0);
    check("rst_irq",   irq_o,       0);
    @(negedge clk);
    @(negedge clk);
    arst_i = 1'b0;
    @(negedge clk);

    // ---- single read, ack 2 cycles after stb ----
    push(1'b0, 3'h2, 8'h00);
    cmd_valid_i = 1'b0;
    check("rd_level1", level_o, 1);
    check("rd_stb_early", wb_stb_o, 0);
    @(negedge clk);
    check("rd_stb", wb_stb_o, 1);
    check("rd_cyc", wb_cyc_o, 1);
    check("rd_addr", wb_addr_o, 3'h2);
    check("rd_we", wb_we_o, 0);
    check("rd_busy", busy_o, 1);
    check("rd_level0", level_o, 0);
    @(negedge clk);
    check("rd_stb_hold", wb_stb_o, 1);
    check("rd_we_hold", wb_we_o, 0);
    @(negedge clk);
    wb_ack_i = 1'b1;
    wb_dat_i = 8'hA5;
    @(negedge clk);
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    check("rd_rspv", rsp_valid_o, 1);
    check("rd_data", rsp_data_o, 8'hA5);
    check("rd_err", rsp_err_o, 0);
    check("rd_stb_off", wb_stb_o, 0);
    check("rd_we_end", wb_we_o, 0);
    // A stray ack in RESP must be ignored.
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    check("rd_rspv_one", rsp_valid_o, 0);
    check("rd_busy_end", busy_o, 0);
    check("rd_stb_idle", wb_stb_o, 0);

    // ---- fill: 5 back-to-back writes, no ack at first ----
    for (int i = 0; i < 5; i++) push(1'b1, 3'(i), 8'h10 + 8'(i));
    cmd_valid_i = 1'b0;
    check("fill_ready_low", cmd_ready_o, 0);
    check("fill_level4", level_o, 4);
    check("fill_stb", wb_stb_o, 1);
    repeat (3) @(negedge clk);
    check("fill_stall_addr", wb_addr_o, 0);
    check("fill_stall_ready", cmd_ready_o, 0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_stb("fill_wait", 20, gap);
        check("fill_gap", (gap >= 1) ? 1 : 0, 1);
      end
      check("fill_level", level_o, 4 - k);
      check("fill_addr", wb_addr_o, k);
      check("fill_dat", wb_dat_o, 8'h10 + k);
      check("fill_we", wb_we_o, 1);
      wb_ack_i = 1'b1;
      wb_dat_i = 8'hEE;
      @(negedge clk);
      wb_ack_i = 1'b0;
      check("fill_rspv", rsp_valid_o, 1);
      check("fill_rdata", rsp_data_o, 0);
      check("fill_stb_off", wb_stb_o, 0);
    end
    @(negedge clk);
    check("fill_done_busy", busy_o, 0);
    check("fill_hold_addr", wb_addr_o, 3'h4);
    check("fill_hold_dat", wb_dat_o, 8'h14);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // ---- timeout: write to 7 with no ack, then a queued read ----
    push(1'b1, 3'h7, 8'h5A);
    push(1'b0, 3'h1, 8'h00);
    cmd_valid_i = 1'b0;
    hi = 0;
    while (wb_stb_o === 1'b1 && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    check("tmo_cycles", hi, 16);
    check("tmo_rspv", rsp_valid_o, 1);
    check("tmo_err", rsp_err_o, 1);
    check("tmo_data", rsp_data_o, 0);
    wait_stb("tmo_next_wait", 10, gap);
    check("tmo_next_addr", wb_addr_o, 3'h1);
    wb_ack_i = 1'b1;
    wb_dat_i = 8'h3C;
    @(negedge clk);
    wb_ack_i = 1'b0;
    check("tmo_next_rspv", rsp_valid_o, 1);
    check("tmo_next_err", rsp_err_o, 0);
    check("tmo_next_data", rsp_data_o, 8'h3C);

    // ---- ack on the expiry edge wins ----
    @(negedge clk);
    push(1'b0, 3'h5, 8'h00);
    cmd_valid_i = 1'b0;
    wait_stb("exp_wait", 10, gap);
    repeat (15) @(negedge clk);
    check("exp_stb16", wb_stb_o, 1);
    wb_ack_i = 1'b1;
    wb_dat_i = 8'h77;
    @(negedge clk);
    wb_ack_i = 1'b0;
    check("exp_rspv", rsp_valid_o, 1);
    check("exp_err", rsp_err_o, 0);
    check("exp_data", rsp_data_o, 8'h77);
    @(negedge clk);
`endif

    // ---- reset in the middle of a bus cycle, 2 commands queued ----
    push(1'b1, 3'h1, 8'h21);
    push(1'b1, 3'h2, 8'h22);
    push(1'b1, 3'h3, 8'h23);
    cmd_valid_i = 1'b0;
    check("mid_stb", wb_stb_o, 1);
    check("mid_level", level_o, 2);
    arst_i = 1'b1;
    #1;
    check("mid_rst_stb", wb_stb_o, 0);
    check("mid_rst_cyc", wb_cyc_o, 0);
    check("mid_rst_level", level_o, 0);
    check("mid_rst_ready", cmd_ready_o, 1);
    check("mid_rst_addr", wb_addr_o, 0);
    @(negedge clk);
    arst_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid_o === 1'b1 || wb_stb_o === 1'b1) pulses++;
    end
    check("mid_no_activity", pulses, 0);
    check("mid_busy", busy_o, 0);

    // ---- interrupt: 3-cycle pulse, delayed by one ----
    check("irq_pre", irq_o, 0);
    wb_inta_i = 1'b1;
    @(negedge clk);
    check("irq_1", irq_o, 1);
    @(negedge clk);
    check("irq_2", irq_o, 1);
    @(negedge clk);
    check("irq_3", irq_o, 1);
    wb_inta_i = 1'b0;
    @(negedge clk);
    check("irq_off", irq_o, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
